// File: rtl/bp_perf_monitor.sv
// Branch-prediction performance monitor: counts cycles, branches and mispredictions over a run.
// Optional miss-PC circular log enabled by defining BP_MON_MISS_LOG_EN.
module bp_perf_monitor #(
    parameter int unsigned CNT_WIDTH   = 32,
    parameter logic [31:0] HALT_INSN   = 32'h0000_006F,
    parameter int unsigned HALT_CYCLES = 8,
    parameter int unsigned LOG_DEPTH   = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic                         br_instr_i,
    input  logic                         br_miss_i,
    input  logic [31:0]                  instr_i,
    input  logic [31:0]                  t_instr_i,
    output logic [CNT_WIDTH-1:0]         cycles_o,
    output logic [CNT_WIDTH-1:0]         br_cnt_o,
    output logic [CNT_WIDTH-1:0]         miss_cnt_o,
    output logic                         rpt_valid_o,
    input  logic                         rpt_ready_i,
    output logic                         done_o,
    output logic                         err_o,
    input  logic [$clog2(LOG_DEPTH)-1:0] log_rd_idx_i,
    output logic [31:0]                  log_pc_o,
    output logic [$clog2(LOG_DEPTH):0]   log_cnt_o
);

    localparam int unsigned HaltW = $clog2(HALT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StRun, StReport, StDone} state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cycles_q, cycles_d;
    logic [CNT_WIDTH-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;
    logic [HaltW-1:0]     halt_cnt_q, halt_cnt_d;
    logic [HaltW-1:0]     halt_inc;
    logic                 rpt_valid_q, rpt_valid_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 log_we;
    logic                 log_clr;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign halt_inc = halt_cnt_q + HaltW'(1);

    always_comb begin
        state_d     = state_q;
        cycles_d    = cycles_q;
        br_cnt_d    = br_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        halt_cnt_d  = halt_cnt_q;
        rpt_valid_d = rpt_valid_q;
        done_d      = done_q;
        err_d       = err_q;
        log_we      = 1'b0;
        log_clr     = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    state_d    = StRun;
                    cycles_d   = '0;
                    br_cnt_d   = '0;
                    miss_cnt_d = '0;
                    halt_cnt_d = '0;
                    err_d      = 1'b0;
                    done_d     = 1'b0;
                    log_clr    = 1'b1;
                end
            end
            StRun: begin
                cycles_d = sat_inc(cycles_q);
                if (br_instr_i) begin
                    br_cnt_d = sat_inc(br_cnt_q);
                end
                if (br_instr_i && br_miss_i) begin
                    miss_cnt_d = sat_inc(miss_cnt_q);
                    log_we     = 1'b1;
                end
                if (br_miss_i && !br_instr_i) begin
                    err_d = 1'b1;
                end
                // Events in the final halt cycle are still counted above.
                if (instr_i == HALT_INSN) begin
                    halt_cnt_d = halt_inc;
                    if (halt_inc == HaltW'(HALT_CYCLES)) begin
                        state_d     = StReport;
                        rpt_valid_d = 1'b1;
                        halt_cnt_d  = '0;
                    end
                end else begin
                    halt_cnt_d = '0;
                end
            end
            StReport: begin
                if (rpt_ready_i) begin
                    state_d     = StDone;
                    rpt_valid_d = 1'b0;
                    done_d      = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            cycles_q    <= '0;
            br_cnt_q    <= '0;
            miss_cnt_q  <= '0;
            halt_cnt_q  <= '0;
            rpt_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cycles_q    <= cycles_d;
            br_cnt_q    <= br_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            halt_cnt_q  <= halt_cnt_d;
            rpt_valid_q <= rpt_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign cycles_o    = cycles_q;
    assign br_cnt_o    = br_cnt_q;
    assign miss_cnt_o  = miss_cnt_q;
    assign rpt_valid_o = rpt_valid_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

`ifdef BP_MON_MISS_LOG_EN
    localparam int unsigned LogAw = $clog2(LOG_DEPTH);

    logic [31:0]      log_mem_q [LOG_DEPTH];
    logic [LogAw-1:0] wr_ptr_q;
    logic [LogAw-1:0] rd_ptr;
    logic [LogAw:0]   log_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || log_clr) begin
            wr_ptr_q  <= '0;
            log_cnt_q <= '0;
        end else if (log_we) begin
            wr_ptr_q <= wr_ptr_q + LogAw'(1);
            if (log_cnt_q != (LogAw + 1)'(LOG_DEPTH)) begin
                log_cnt_q <= log_cnt_q + (LogAw + 1)'(1);
            end
        end
    end

    // Entry contents need no reset: reads beyond log_cnt_q are masked to zero.
    always_ff @(posedge clk_i) begin
        if (log_we && !rst_i) begin
            log_mem_q[wr_ptr_q] <= t_instr_i;
        end
    end

    // Index 0 is the most recent write, one behind the write pointer.
    assign rd_ptr    = wr_ptr_q - LogAw'(1) - log_rd_idx_i;
    assign log_pc_o  = ({1'b0, log_rd_idx_i} < log_cnt_q) ? log_mem_q[rd_ptr] : 32'h0;
    assign log_cnt_o = log_cnt_q;
`else
    logic unused_log;
    assign unused_log = ^{log_we, log_clr, t_instr_i, log_rd_idx_i};
    assign log_pc_o   = 32'h0;
    assign log_cnt_o  = '0;
`endif

endmodule

// File: doc/bp_perf_monitor.md
# bp_perf_monitor

Branch-prediction performance monitor that sits directly downstream of the predictor core's observation taps in the simulation top. Consumes the per-cycle branch-resolved, misprediction, fetched-instruction and resolved-PC signals, counts cycles, branches and mispredictions over one program run, and detects program end from a self-loop halt instruction. Presents a single result snapshot to the bench over a valid/ready handshake, and optionally logs the PCs of the most recent mispredictions.

## Interface
- CNT_WIDTH, 32, width of all event counters
- HALT_INSN, 32'h0000_006F, fetched instruction word that marks program end (jal x0,0)
- HALT_CYCLES, 8, consecutive HALT_INSN fetches needed to declare end (≥1)
- LOG_DEPTH, 8, miss-PC log entries (power of two, ≥2)

- clk_i  in  1  clock; one clock domain
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  begin a run (honoured in IDLE and DONE)
- br_instr_i  in  1  a branch/jump resolved this cycle
- br_miss_i  in  1  that branch was mispredicted
- instr_i  in  32  instruction word fetched this cycle
- t_instr_i  in  32  PC of the resolving branch
- cycles_o  out  CNT_WIDTH  cycles spent in RUN
- br_cnt_o  out  CNT_WIDTH  resolved branches
- miss_cnt_o  out  CNT_WIDTH  mispredictions
- rpt_valid_o  out  1  snapshot valid
- rpt_ready_i  in  1  bench accepts snapshot
- done_o  out  1  run complete and snapshot accepted
- err_o  out  1  sticky: br_miss_i seen without br_instr_i
- log_rd_idx_i  in  $clog2(LOG_DEPTH)  log read index, 0 = most recent
- log_pc_o  out  32  logged miss PC at log_rd_idx_i
- log_cnt_o  out  $clog2(LOG_DEPTH)+1  valid log entries

## Operation
- States: IDLE, RUN, REPORT, DONE. Reset → IDLE.
- IDLE/DONE: start_i=1 → RUN next edge; counters, halt counter, err_o and log cleared on that same edge.
- RUN: every cycle cycles_o += 1; br_instr_i → br_cnt_o += 1; br_instr_i & br_miss_i → miss_cnt_o += 1 (and log write).
- br_miss_i & !br_instr_i: not counted, err_o set sticky until next start or reset.
- All counters saturate at all-ones; no wrap.
- Halt detect: instr_i == HALT_INSN increments match count, any other word clears it. When the match count reaches HALT_CYCLES, RUN → REPORT on that edge; events sampled in that cycle are still counted.
- REPORT: counters frozen, rpt_valid_o=1; held until rpt_valid_o & rpt_ready_i, then → DONE. Inputs other than rpt_ready_i and rst_i ignored.
- DONE: done_o=1, counters hold their values for reading.
- start_i in RUN or REPORT ignored.

## Timing
- All outputs registered; counts visible one cycle after the sampled event.
- Reset values: all counters 0, rpt_valid_o 0, done_o 0, err_o 0, log_cnt_o 0, log_pc_o 0.
- Halt latency: REPORT entered on the edge after the HALT_CYCLES-th consecutive match; rpt_valid_o high from that edge.
- Handshake: rpt_valid_o never drops without a transfer; rpt_ready_i may be high before valid; transfer completes in one cycle if both high.
- rst_i mid-run or mid-REPORT: everything returns to reset values on that edge, no report emitted.

## Configuration
- BP_MON_MISS_LOG_EN defined: circular buffer of LOG_DEPTH 32-bit entries; each counted miss writes t_instr_i at the write pointer, pointer wraps modulo LOG_DEPTH, oldest overwritten; log_cnt_o saturates at LOG_DEPTH; log_pc_o combinational read, index ≥ log_cnt_o returns 0; log cleared on start.
- Not defined: no storage; log_pc_o and log_cnt_o tied to 0.

## Test plan
- Reset, start, 20 cycles of non-halt instr with 5 branches, 2 misses, then 8 × HALT_INSN → REPORT with br_cnt_o=5 (+halt jumps driven), miss_cnt_o=2, cycles_o=28.
- 7 × HALT_INSN, one other word, 8 × HALT_INSN → no REPORT until the 8th of the final run.
- In REPORT, hold rpt_ready_i=0 for 5 cycles while toggling br_instr_i → rpt_valid_o stays 1, counters unchanged; raise ready → DONE next edge, done_o=1.
- br_miss_i=1 with br_instr_i=0 → miss_cnt_o unchanged, err_o=1 until next start.
- With BP_MON_MISS_LOG_EN, 10 misses at PCs 0x100..0x124 step 4 → log_cnt_o=8, idx0=0x124, idx7=0x108.
- rst_i asserted mid-RUN with counts nonzero → all outputs 0, state IDLE; new start produces fresh counts.
